// File: rtl/riscv_pkg.sv
// Core-wide RV32I widths and the ID/EX payload types shared by the pipeline registers.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_W   = 7;

    typedef struct packed {
        logic regwrite;
        logic alusrc;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
        logic jump;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_NOP = '0;

    typedef struct packed {
        id_ex_ctrl_t             ctrl;
        logic [XLEN-1:0]         read_data1;
        logic [XLEN-1:0]         read_data2;
        logic [XLEN-1:0]         imm;
        logic [XLEN-1:0]         pc;
        logic [REG_ADDR_W-1:0]   rs1;
        logic [REG_ADDR_W-1:0]   rs2;
        logic [REG_ADDR_W-1:0]   rd;
        logic [FUNCT3_W-1:0]     funct3;
        logic [FUNCT7_W-1:0]     funct7;
    } id_ex_bus_t;

endpackage

// File: rtl/pipeline_reg_id_ex_pipe_reg.sv
// Generic pipeline flop: synchronous clear beats hold, hold beats load.
module pipe_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_reg_id_ex.sv
// ID/EX pipeline register: one flop bank over the whole payload; reset or flush loads a NOP bubble.
module pipeline_reg_id_ex
    import riscv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  regwrite_in,
    input  logic                  alusrc_in,
    input  logic                  memread_in,
    input  logic                  memwrite_in,
    input  logic                  memtoreg_in,
    input  logic                  branch_in,
    input  logic                  jump_in,
    input  logic [XLEN-1:0]       read_data1_in,
    input  logic [XLEN-1:0]       read_data2_in,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [REG_ADDR_W-1:0] rs1_in,
    input  logic [REG_ADDR_W-1:0] rs2_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [FUNCT3_W-1:0]   funct3_in,
    input  logic [FUNCT7_W-1:0]   funct7_in,
    output logic                  regwrite_out,
    output logic                  alusrc_out,
    output logic                  memread_out,
    output logic                  memwrite_out,
    output logic                  memtoreg_out,
    output logic                  branch_out,
    output logic                  jump_out,
    output logic [XLEN-1:0]       read_data1_out,
    output logic [XLEN-1:0]       read_data2_out,
    output logic [XLEN-1:0]       imm_out,
    output logic [XLEN-1:0]       pc_out,
    output logic [REG_ADDR_W-1:0] rs1_out,
    output logic [REG_ADDR_W-1:0] rs2_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [FUNCT3_W-1:0]   funct3_out,
    output logic [FUNCT7_W-1:0]   funct7_out
);

    id_ex_bus_t next_bus;
    id_ex_bus_t cur_bus;

    always_comb begin
        next_bus                = '0;
        next_bus.ctrl.regwrite  = regwrite_in;
        next_bus.ctrl.alusrc    = alusrc_in;
        next_bus.ctrl.memread   = memread_in;
        next_bus.ctrl.memwrite  = memwrite_in;
        next_bus.ctrl.memtoreg  = memtoreg_in;
        next_bus.ctrl.branch    = branch_in;
        next_bus.ctrl.jump      = jump_in;
        next_bus.read_data1     = read_data1_in;
        next_bus.read_data2     = read_data2_in;
        next_bus.imm            = imm_in;
        next_bus.pc             = pc_in;
        next_bus.rs1            = rs1_in;
        next_bus.rs2            = rs2_in;
        next_bus.rd             = rd_in;
        next_bus.funct3         = funct3_in;
        next_bus.funct7         = funct7_in;
    end

    // Flush zeroes data and indices too, so rd_out=0 hides the bubble from forwarding.
    pipe_reg #(
        .WIDTH($bits(id_ex_bus_t))
    ) u_bus_reg (
        .clk   (clock),
        .clear (reset | flush),
        .hold  (stall),
        .d     (next_bus),
        .q     (cur_bus)
    );

    assign regwrite_out   = cur_bus.ctrl.regwrite;
    assign alusrc_out     = cur_bus.ctrl.alusrc;
    assign memread_out    = cur_bus.ctrl.memread;
    assign memwrite_out   = cur_bus.ctrl.memwrite;
    assign memtoreg_out   = cur_bus.ctrl.memtoreg;
    assign branch_out     = cur_bus.ctrl.branch;
    assign jump_out       = cur_bus.ctrl.jump;
    assign read_data1_out = cur_bus.read_data1;
    assign read_data2_out = cur_bus.read_data2;
    assign imm_out        = cur_bus.imm;
    assign pc_out         = cur_bus.pc;
    assign rs1_out        = cur_bus.rs1;
    assign rs2_out        = cur_bus.rs2;
    assign rd_out         = cur_bus.rd;
    assign funct3_out     = cur_bus.funct3;
    assign funct7_out     = cur_bus.funct7;

endmodule

// File: tb/tb_pipeline_reg_id_ex.sv
// Scoreboarded bench for pipeline_reg_id_ex: expectations queued at drive time, compared after each edge.
module tb_pipeline_reg_id_ex;
    import riscv_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       stall = 1'b0;
    id_ex_bus_t in_bus = '0;

    logic                  regwrite_out, alusrc_out, memread_out, memwrite_out;
    logic                  memtoreg_out, branch_out, jump_out;
    logic [XLEN-1:0]       read_data1_out, read_data2_out, imm_out, pc_out;
    logic [REG_ADDR_W-1:0] rs1_out, rs2_out, rd_out;
    logic [FUNCT3_W-1:0]   funct3_out;
    logic [FUNCT7_W-1:0]   funct7_out;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    id_ex_bus_t sb[$];
    id_ex_bus_t model = '0;

    always #5 clock = ~clock;

    pipeline_reg_id_ex dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .stall          (stall),
        .regwrite_in    (in_bus.ctrl.regwrite),
        .alusrc_in      (in_bus.ctrl.alusrc),
        .memread_in     (in_bus.ctrl.memread),
        .memwrite_in    (in_bus.ctrl.memwrite),
        .memtoreg_in    (in_bus.ctrl.memtoreg),
        .branch_in      (in_bus.ctrl.branch),
        .jump_in        (in_bus.ctrl.jump),
        .read_data1_in  (in_bus.read_data1),
        .read_data2_in  (in_bus.read_data2),
        .imm_in         (in_bus.imm),
        .pc_in          (in_bus.pc),
        .rs1_in         (in_bus.rs1),
        .rs2_in         (in_bus.rs2),
        .rd_in          (in_bus.rd),
        .funct3_in      (in_bus.funct3),
        .funct7_in      (in_bus.funct7),
        .regwrite_out   (regwrite_out),
        .alusrc_out     (alusrc_out),
        .memread_out    (memread_out),
        .memwrite_out   (memwrite_out),
        .memtoreg_out   (memtoreg_out),
        .branch_out     (branch_out),
        .jump_out       (jump_out),
        .read_data1_out (read_data1_out),
        .read_data2_out (read_data2_out),
        .imm_out        (imm_out),
        .pc_out         (pc_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rd_out         (rd_out),
        .funct3_out     (funct3_out),
        .funct7_out     (funct7_out)
    );

    function automatic id_ex_bus_t observed();
        id_ex_bus_t o;
        o.ctrl.regwrite = regwrite_out;
        o.ctrl.alusrc   = alusrc_out;
        o.ctrl.memread  = memread_out;
        o.ctrl.memwrite = memwrite_out;
        o.ctrl.memtoreg = memtoreg_out;
        o.ctrl.branch   = branch_out;
        o.ctrl.jump     = jump_out;
        o.read_data1    = read_data1_out;
        o.read_data2    = read_data2_out;
        o.imm           = imm_out;
        o.pc            = pc_out;
        o.rs1           = rs1_out;
        o.rs2           = rs2_out;
        o.rd            = rd_out;
        o.funct3        = funct3_out;
        o.funct7        = funct7_out;
        return o;
    endfunction

    function automatic id_ex_bus_t rand_bus();
        id_ex_bus_t b;
        b.ctrl       = id_ex_ctrl_t'($urandom_range(0, 127));
        b.read_data1 = $urandom;
        b.read_data2 = $urandom;
        b.imm        = $urandom;
        b.pc         = $urandom;
        b.rs1        = REG_ADDR_W'($urandom_range(0, 31));
        b.rs2        = REG_ADDR_W'($urandom_range(0, 31));
        b.rd         = REG_ADDR_W'($urandom_range(1, 31));
        b.funct3     = FUNCT3_W'($urandom_range(0, 7));
        b.funct7     = FUNCT7_W'($urandom_range(0, 127));
        return b;
    endfunction

    // Drive one edge; the expected result is queued from the priority rules before the edge.
    task automatic step(input id_ex_bus_t in, input logic rst, input logic fl, input logic st);
        id_ex_bus_t e;
        in_bus = in;
        reset  = rst;
        flush  = fl;
        stall  = st;
        if (rst || fl)  e = '0;
        else if (st)    e = model;
        else            e = in;
        model = e;
        sb.push_back(e);
        @(posedge clock);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        id_ex_bus_t in, e, o;
        in            = '0;
        in.ctrl       = '1;
        in.read_data1 = 32'hAAAA_AAAA;
        in.pc         = 32'd100;
        in.rd         = 5'd12;
        step(in, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_all got=%h want=%h", o, e);
        end
        checks++;
        if (o !== id_ex_bus_t'('0)) begin
            failures++;
            $display("FAIL reset_zero got=%h want=0", o);
        end
    endtask

    task automatic test_add();
        id_ex_bus_t in, e, o;
        in               = '0;
        in.ctrl.regwrite = 1'b1;
        in.read_data1    = 32'd10;
        in.read_data2    = 32'd20;
        in.rd            = 5'd3;
        in.funct3        = 3'd0;
        step(in, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL add_bus got=%h want=%h", o, e);
        end
        checks++;
        if ({regwrite_out, alusrc_out, read_data1_out, read_data2_out, rd_out}
            !== {1'b1, 1'b0, 32'd10, 32'd20, 5'd3}) begin
            failures++;
            $display("FAIL add_fields got rw=%b as=%b r1=%0d r2=%0d rd=%0d want rw=1 as=0 r1=10 r2=20 rd=3",
                     regwrite_out, alusrc_out, read_data1_out, read_data2_out, rd_out);
        end
    endtask

    task automatic test_load_store();
        id_ex_bus_t ld, stv, e, o;
        ld               = '0;
        ld.ctrl.regwrite = 1'b1;
        ld.ctrl.alusrc   = 1'b1;
        ld.ctrl.memread  = 1'b1;
        ld.ctrl.memtoreg = 1'b1;
        ld.imm           = 32'd100;
        ld.rd            = 5'd7;
        ld.funct3        = 3'd2;
        stv              = '0;
        stv.ctrl.alusrc  = 1'b1;
        stv.ctrl.memwrite = 1'b1;
        stv.read_data2   = 32'h1234_5678;
        stv.imm          = 32'd200;
        stv.funct3       = 3'd2;
        step(ld, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL load_bus got=%h want=%h", o, e);
        end
        step(stv, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL store_bus got=%h want=%h", o, e);
        end
        checks++;
        if ({memwrite_out, memread_out, regwrite_out, read_data2_out, imm_out}
            !== {1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'd200}) begin
            failures++;
            $display("FAIL store_fields got mw=%b mr=%b rw=%b r2=%h imm=%0d want mw=1 mr=0 rw=0 r2=12345678 imm=200",
                     memwrite_out, memread_out, regwrite_out, read_data2_out, imm_out);
        end
    endtask

    task automatic test_stall();
        id_ex_bus_t jmp, nw, e, o;
        jmp               = '0;
        jmp.ctrl.jump     = 1'b1;
        jmp.ctrl.regwrite = 1'b1;
        jmp.imm           = 32'd1000;
        jmp.rd            = 5'd1;
        step(jmp, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL jump_load got=%h want=%h", o, e);
        end
        nw               = '0;
        nw.ctrl          = '1;
        nw.ctrl.regwrite = 1'b0;
        nw.read_data1    = 32'hFFFF_FFFF;
        step(nw, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL stall_hold1 got=%h want=%h", o, e);
        end
        checks++;
        if ({jump_out, regwrite_out, imm_out, read_data1_out} !== {1'b1, 1'b1, 32'd1000, 32'd0}) begin
            failures++;
            $display("FAIL stall_fields got j=%b rw=%b imm=%0d r1=%h want j=1 rw=1 imm=1000 r1=0",
                     jump_out, regwrite_out, imm_out, read_data1_out);
        end
        nw.read_data1 = 32'hAAAA_AAAA;
        nw.rd         = 5'd22;
        step(nw, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL stall_hold2 got=%h want=%h", o, e);
        end
        step(nw, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL stall_release got=%h want=%h", o, e);
        end
        checks++;
        if ({rd_out, read_data1_out} !== {5'd22, 32'hAAAA_AAAA}) begin
            failures++;
            $display("FAIL release_fields got rd=%0d r1=%h want rd=22 r1=aaaaaaaa", rd_out, read_data1_out);
        end
    endtask

    task automatic test_flush();
        id_ex_bus_t in, e, o;
        in            = rand_bus();
        in.ctrl       = '1;
        in.read_data1 = 32'h9999_9999;
        step(in, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL flush_bus got=%h want=%h", o, e);
        end
        checks++;
        if ({regwrite_out, memread_out, memwrite_out, branch_out, jump_out, read_data1_out, rd_out} !== '0) begin
            failures++;
            $display("FAIL flush_fields got rw=%b mr=%b mw=%b br=%b j=%b r1=%h rd=%0d want all 0",
                     regwrite_out, memread_out, memwrite_out, branch_out, jump_out, read_data1_out, rd_out);
        end
    endtask

    task automatic test_back_to_back();
        id_ex_bus_t in, e, o;
        for (int i = 0; i < 12; i++) begin
            in = rand_bus();
            step(in, 1'b0, (i % 4) == 2, (i % 5) == 3);
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_priority();
        id_ex_bus_t in, e, o;
        in = rand_bus();
        step(in, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL prio_load1 got=%h want=%h", o, e);
        end
        step(rand_bus(), 1'b0, 1'b1, 1'b1);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL flush_stall got=%h want=%h", o, e);
        end
        step(in, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL prio_load2 got=%h want=%h", o, e);
        end
        step(rand_bus(), 1'b1, 1'b0, 1'b1);
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_stall got=%h want=%h", o, e);
        end
        checks++;
        if (o !== id_ex_bus_t'('0)) begin
            failures++;
            $display("FAIL reset_stall_zero got=%h want=0", o);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_add();
        test_load_store();
        test_stall();
        test_flush();
        test_back_to_back();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
